// File: rtl/axppa_pkg.sv
// Shared definitions for the approximate-adder error monitor: default
// adder width, monitor FSM states and a small unsigned max helper.
package axppa_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Unsigned maximum; ties return the first argument so a running max is
  // left untouched when the new value merely equals it.
  function automatic logic [31:0] max_u(input logic [31:0] a, input logic [31:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/ed_stage.sv
// Stage 1 of the error monitor: forms the signed difference approx-exact,
// its magnitude (error distance) and a nonzero flag, and registers them on
// the edge that accepts the sample together with a valid flag.
module ed_stage
  import axppa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_accept,
  input  logic [WIDTH-1:0]        i_exact,
  input  logic [WIDTH-1:0]        i_approx,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_ed,
  output logic                    o_nz,
  output logic signed [WIDTH:0]   o_diff
);

  logic [WIDTH:0]         w_diff;
  logic [WIDTH-1:0]       w_ed;
  logic                   w_nz;

  logic                   r_valid;
  logic [WIDTH-1:0]       r_ed;
  logic                   r_nz;
  logic signed [WIDTH:0]  r_diff;

  // Difference is exact in WIDTH+1 bits because both operands are unsigned
  // WIDTH-bit values; its magnitude always fits back into WIDTH bits.
  always_comb begin
    w_diff = {1'b0, i_approx} - {1'b0, i_exact};
    w_ed   = w_diff[WIDTH] ? WIDTH'(-w_diff) : w_diff[WIDTH-1:0];
    w_nz   = |w_ed;
  end

  // Stage-1 register: valid follows acceptance, payload captured on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ed    <= '0;
      r_nz    <= 1'b0;
      r_diff  <= '0;
    end else begin
      r_valid <= i_accept;
      if (i_accept) begin
        r_ed   <= w_ed;
        r_nz   <= w_nz;
        r_diff <= $signed(w_diff);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ed    = r_ed;
  assign o_nz    = r_nz;
  assign o_diff  = r_diff;

endmodule

// File: rtl/adder_error_monitor.sv
// Streaming error-statistics collector for exact vs approximate adder sums.
// Collects error count, sum of error distance, max error distance and
// signed bias over NUM_SAMPLES accepted samples, then offers the results
// on a ready/valid port until the consumer takes them.
module adder_error_monitor
  import axppa_pkg::*;
#(
  parameter  int WIDTH       = WIDTH_DEFAULT,
  parameter  int NUM_SAMPLES = 256,
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1),
  localparam int ACC_W       = WIDTH + CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      sum_exact,
  input  logic [WIDTH-1:0]      sum_approx,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      err_count,
  output logic [ACC_W-1:0]      ed_sum,
  output logic [WIDTH-1:0]      ed_max,
  output logic signed [ACC_W:0] bias_sum
);

  state_t                 r_state;
  state_t                 w_state_next;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_clear;

  logic                   w_s1_valid;
  logic [WIDTH-1:0]       w_s1_ed;
  logic                   w_s1_nz;
  logic signed [WIDTH:0]  w_s1_diff;

  logic [CNT_W-1:0]       r_sample_cnt;
  logic [CNT_W-1:0]       r_err_count;
  logic [ACC_W-1:0]       r_ed_sum;
  logic [WIDTH-1:0]       r_ed_max;
  logic signed [ACC_W:0]  r_bias_sum;

  assign in_ready  = (r_state == RUN);
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign res_valid = (r_state == REPORT);

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_sample_cnt == CNT_W'(NUM_SAMPLES - 1));
  assign w_clear   = (r_state == IDLE) && start;

  ed_stage #(
    .WIDTH (WIDTH)
  ) u_ed_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_accept),
    .i_exact  (sum_exact),
    .i_approx (sum_approx),
    .o_valid  (w_s1_valid),
    .o_ed     (w_s1_ed),
    .o_nz     (w_s1_nz),
    .o_diff   (w_s1_diff)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. DRAIN never accepts a sample, so stage 1 is empty
  // after the first DRAIN edge and REPORT follows one cycle later.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_accept && w_last) w_state_next = DRAIN;
      DRAIN:   if (!w_accept) w_state_next = REPORT;
      REPORT:  if (res_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Sample counter: cleared by start in IDLE, bumped on each acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
    end else if (w_clear) begin
      r_sample_cnt <= '0;
    end else if (w_accept) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
    end
  end

  // Stage 2: fold the registered stage-1 result into the accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
      r_bias_sum  <= '0;
    end else if (w_clear) begin
      r_err_count <= '0;
      r_ed_sum    <= '0;
      r_ed_max    <= '0;
      r_bias_sum  <= '0;
    end else if (w_s1_valid) begin
      r_err_count <= r_err_count + CNT_W'(w_s1_nz);
      r_ed_sum    <= r_ed_sum + ACC_W'(w_s1_ed);
      r_ed_max    <= WIDTH'(max_u(32'(r_ed_max), 32'(w_s1_ed)));
      r_bias_sum  <= r_bias_sum + (ACC_W + 1)'(w_s1_diff);
    end
  end

  assign err_count = r_err_count;
  assign ed_sum    = r_ed_sum;
  assign ed_max    = r_ed_max;
  assign bias_sum  = r_bias_sum;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed bench for adder_error_monitor: three instances cover
// NUM_SAMPLES = 4 (main scenarios), 1 (boundary) and 256 (no overflow).
module tb_adder_error_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // NUM_SAMPLES = 4 instance
  logic              rst_n4, start4, in_valid4, res_ready4;
  logic [7:0]        exact4, approx4;
  logic              in_ready4, busy4, res_valid4;
  logic [2:0]        err4;
  logic [10:0]       ed_sum4;
  logic [7:0]        ed_max4;
  logic signed [11:0] bias4;

  // NUM_SAMPLES = 1 instance
  logic              rst_n1, start1, in_valid1, res_ready1;
  logic [7:0]        exact1, approx1;
  logic              in_ready1, busy1, res_valid1;
  logic [0:0]        err1;
  logic [8:0]        ed_sum1;
  logic [7:0]        ed_max1;
  logic signed [9:0] bias1;

  // NUM_SAMPLES = 256 instance
  logic              rst_n256, start256, in_valid256, res_ready256;
  logic [7:0]        exact256, approx256;
  logic              in_ready256, busy256, res_valid256;
  logic [8:0]        err256;
  logic [16:0]       ed_sum256;
  logic [7:0]        ed_max256;
  logic signed [17:0] bias256;

  adder_error_monitor #(.WIDTH(8), .NUM_SAMPLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .in_valid(in_valid4),
    .in_ready(in_ready4), .sum_exact(exact4), .sum_approx(approx4),
    .busy(busy4), .res_valid(res_valid4), .res_ready(res_ready4),
    .err_count(err4), .ed_sum(ed_sum4), .ed_max(ed_max4), .bias_sum(bias4)
  );

  adder_error_monitor #(.WIDTH(8), .NUM_SAMPLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sum_exact(exact1), .sum_approx(approx1),
    .busy(busy1), .res_valid(res_valid1), .res_ready(res_ready1),
    .err_count(err1), .ed_sum(ed_sum1), .ed_max(ed_max1), .bias_sum(bias1)
  );

  adder_error_monitor #(.WIDTH(8), .NUM_SAMPLES(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n256), .start(start256), .in_valid(in_valid256),
    .in_ready(in_ready256), .sum_exact(exact256), .sum_approx(approx256),
    .busy(busy256), .res_valid(res_valid256), .res_ready(res_ready256),
    .err_count(err256), .ed_sum(ed_sum256), .ed_max(ed_max256), .bias_sum(bias256)
  );

  // Basic run vectors: expected err=3, ed_sum=269, ed_max=255, bias=+249
  logic [7:0] ex_a [4] = '{8'd10, 8'd200, 8'd5, 8'd0};
  logic [7:0] ap_a [4] = '{8'd10, 8'd190, 8'd9, 8'd255};
  // Second run vectors: diffs +1,0,-50,0 -> err=2, ed_sum=51, ed_max=50, bias=-49
  logic [7:0] ex_b [4] = '{8'd1, 8'd3, 8'd100, 8'd7};
  logic [7:0] ap_b [4] = '{8'd2, 8'd3, 8'd50, 8'd7};

  task automatic test_reset();
    rst_n4 = 0; start4 = 0; in_valid4 = 0; res_ready4 = 0; exact4 = 0; approx4 = 0;
    rst_n1 = 0; start1 = 0; in_valid1 = 0; res_ready1 = 0; exact1 = 0; approx1 = 0;
    rst_n256 = 0; start256 = 0; in_valid256 = 0; res_ready256 = 0; exact256 = 0; approx256 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready4, busy4, res_valid4} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl4 got %b expected 000", {in_ready4, busy4, res_valid4});
    end
    checks++;
    if (err4 !== 3'd0 || ed_sum4 !== 11'd0 || ed_max4 !== 8'd0 || bias4 !== 12'sd0) begin
      errors++; $display("FAIL reset_acc4 got %0d/%0d/%0d/%0d expected 0/0/0/0", err4, ed_sum4, ed_max4, bias4);
    end
    checks++;
    if ({in_ready1, busy1, res_valid1, in_ready256, busy256, res_valid256} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_other got %b expected 000000",
                         {in_ready1, busy1, res_valid1, in_ready256, busy256, res_valid256});
    end
    rst_n4 = 1; rst_n1 = 1; rst_n256 = 1;
    @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got in_ready=%b busy=%b expected 0 0", in_ready4, busy4);
    end
  endtask

  task automatic test_basic();
    @(negedge clk); start4 = 1;
    @(negedge clk); start4 = 0;
    checks++;
    if (in_ready4 !== 1'b1 || busy4 !== 1'b1) begin
      errors++; $display("FAIL basic_run_entry got in_ready=%b busy=%b expected 1 1", in_ready4, busy4);
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      in_valid4 = 1; exact4 = ex_a[i]; approx4 = ap_a[i];
    end
    @(negedge clk); in_valid4 = 0;
    checks++;
    if ({in_ready4, busy4, res_valid4} !== 3'b010) begin
      errors++; $display("FAIL basic_drain got in_ready,busy,res_valid=%b expected 010", {in_ready4, busy4, res_valid4});
    end
    @(negedge clk);
    checks++;
    if (res_valid4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++; $display("FAIL basic_report got res_valid=%b busy=%b expected 1 0", res_valid4, busy4);
    end
    checks++;
    if (err4 !== 3'd3 || ed_sum4 !== 11'd269 || ed_max4 !== 8'd255 || bias4 !== 12'sd249) begin
      errors++; $display("FAIL basic_results got %0d/%0d/%0d/%0d expected 3/269/255/249", err4, ed_sum4, ed_max4, bias4);
    end
    $display("run basic: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err4, ed_sum4, ed_max4, bias4);
    res_ready4 = 1;
    @(negedge clk); res_ready4 = 0;
    checks++;
    if (res_valid4 !== 1'b0 || busy4 !== 1'b0 || ed_sum4 !== 11'd269) begin
      errors++; $display("FAIL basic_release got res_valid=%b busy=%b ed_sum=%0d expected 0 0 269", res_valid4, busy4, ed_sum4);
    end
  endtask

  task automatic test_backpressure();
    int gaps [4] = '{0, 1, 2, 3};
    int n;
    @(negedge clk); start4 = 1;
    @(negedge clk); start4 = 0; in_valid4 = 0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        @(negedge clk); in_valid4 = 0; exact4 = 8'd77; approx4 = 8'd3;
      end
      @(negedge clk); in_valid4 = 1; exact4 = ex_a[i]; approx4 = ap_a[i];
    end
    @(negedge clk); in_valid4 = 0;
    n = 0;
    while (res_valid4 !== 1'b1 && n < 6) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL bp_report_latency got %0d cycles expected 1", n);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (res_valid4 !== 1'b1 || err4 !== 3'd3 || ed_sum4 !== 11'd269 || ed_max4 !== 8'd255 || bias4 !== 12'sd249) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b %0d/%0d/%0d/%0d expected 1 3/269/255/249",
                           c, res_valid4, err4, ed_sum4, ed_max4, bias4);
      end
      @(negedge clk);
    end
    $display("run backpressure: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err4, ed_sum4, ed_max4, bias4);
    res_ready4 = 1;
    @(negedge clk); res_ready4 = 0;
    checks++;
    if ({in_ready4, busy4, res_valid4} !== 3'b000) begin
      errors++; $display("FAIL bp_idle got %b expected 000", {in_ready4, busy4, res_valid4});
    end
  endtask

  task automatic test_ignored();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); in_valid4 = 1; exact4 = 8'd0; approx4 = 8'd255;
      checks++;
      if (in_ready4 !== 1'b0) begin
        errors++; $display("FAIL idle_in_ready got %b expected 0", in_ready4);
      end
    end
    @(negedge clk); in_valid4 = 0; start4 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start4 = (i == 2);
      in_valid4 = 1; exact4 = ex_a[i]; approx4 = ap_a[i];
    end
    // offered during DRAIN and REPORT, never taken
    @(negedge clk); start4 = 0; in_valid4 = 1; exact4 = 8'd0; approx4 = 8'd255;
    @(negedge clk);
    checks++;
    if (res_valid4 !== 1'b1) begin
      errors++; $display("FAIL ign_report got res_valid=%b expected 1", res_valid4);
    end
    start4 = 1;
    @(negedge clk);
    checks++;
    if (res_valid4 !== 1'b1 || err4 !== 3'd3 || ed_sum4 !== 11'd269 || ed_max4 !== 8'd255 || bias4 !== 12'sd249) begin
      errors++; $display("FAIL ign_results got v=%b %0d/%0d/%0d/%0d expected 1 3/269/255/249",
                         res_valid4, err4, ed_sum4, ed_max4, bias4);
    end
    $display("run ignored: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err4, ed_sum4, ed_max4, bias4);
    res_ready4 = 1;
    @(negedge clk); res_ready4 = 0; start4 = 0; in_valid4 = 0;
    checks++;
    if ({in_ready4, busy4, res_valid4} !== 3'b000 || ed_sum4 !== 11'd269) begin
      errors++; $display("FAIL ign_start_at_handshake got %b ed_sum=%0d expected 000 269",
                         {in_ready4, busy4, res_valid4}, ed_sum4);
    end
    // second run must not inherit anything from the first
    @(negedge clk); start4 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start4 = 0; in_valid4 = 1; exact4 = ex_b[i]; approx4 = ap_b[i];
    end
    @(negedge clk); in_valid4 = 0;
    @(negedge clk);
    checks++;
    if (res_valid4 !== 1'b1 || err4 !== 3'd2 || ed_sum4 !== 11'd51 || ed_max4 !== 8'd50 || bias4 !== -12'sd49) begin
      errors++; $display("FAIL run2_results got v=%b %0d/%0d/%0d/%0d expected 1 2/51/50/-49",
                         res_valid4, err4, ed_sum4, ed_max4, bias4);
    end
    $display("run second: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err4, ed_sum4, ed_max4, bias4);
    res_ready4 = 1;
    @(negedge clk); res_ready4 = 0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk); start4 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); start4 = 0; in_valid4 = 1; exact4 = ex_a[i]; approx4 = ap_a[i];
    end
    @(negedge clk); in_valid4 = 0; rst_n4 = 0;
    @(negedge clk);
    checks++;
    if ({in_ready4, busy4, res_valid4} !== 3'b000 || err4 !== 3'd0 || ed_sum4 !== 11'd0 ||
        ed_max4 !== 8'd0 || bias4 !== 12'sd0) begin
      errors++; $display("FAIL midrun_reset got ctrl=%b %0d/%0d/%0d/%0d expected 000 0/0/0/0",
                         {in_ready4, busy4, res_valid4}, err4, ed_sum4, ed_max4, bias4);
    end
    rst_n4 = 1;
    @(negedge clk); start4 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start4 = 0; in_valid4 = 1; exact4 = ex_a[i]; approx4 = ap_a[i];
    end
    @(negedge clk); in_valid4 = 0;
    @(negedge clk);
    checks++;
    if (res_valid4 !== 1'b1 || err4 !== 3'd3 || ed_sum4 !== 11'd269 || ed_max4 !== 8'd255 || bias4 !== 12'sd249) begin
      errors++; $display("FAIL after_reset_run got v=%b %0d/%0d/%0d/%0d expected 1 3/269/255/249",
                         res_valid4, err4, ed_sum4, ed_max4, bias4);
    end
    $display("run after reset: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err4, ed_sum4, ed_max4, bias4);
    res_ready4 = 1;
    @(negedge clk); res_ready4 = 0;
  endtask

  task automatic test_single_sample();
    @(negedge clk); start1 = 1;
    @(negedge clk); start1 = 0; in_valid1 = 1; exact1 = 8'd255; approx1 = 8'd0;
    @(negedge clk); in_valid1 = 0;
    checks++;
    if (in_ready1 !== 1'b0 || busy1 !== 1'b1 || res_valid1 !== 1'b0) begin
      errors++; $display("FAIL n1_drain got in_ready=%b busy=%b res_valid=%b expected 0 1 0", in_ready1, busy1, res_valid1);
    end
    @(negedge clk);
    checks++;
    if (res_valid1 !== 1'b1 || err1 !== 1'd1 || ed_sum1 !== 9'd255 || ed_max1 !== 8'd255 || bias1 !== -10'sd255) begin
      errors++; $display("FAIL n1_results got v=%b %0d/%0d/%0d/%0d expected 1 1/255/255/-255",
                         res_valid1, err1, ed_sum1, ed_max1, bias1);
    end
    $display("run single: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err1, ed_sum1, ed_max1, bias1);
    res_ready1 = 1;
    @(negedge clk); res_ready1 = 0;
  endtask

  task automatic test_overflow();
    int n;
    @(negedge clk); start256 = 1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); start256 = 0; in_valid256 = 1; exact256 = 8'd0; approx256 = 8'd255;
    end
    @(negedge clk); in_valid256 = 0;
    checks++;
    if (in_ready256 !== 1'b0) begin
      errors++; $display("FAIL n256_drain got in_ready=%b expected 0", in_ready256);
    end
    n = 0;
    while (res_valid256 !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL n256_report_latency got %0d cycles expected 1", n);
    end
    checks++;
    if (err256 !== 9'd256 || ed_sum256 !== 17'd65280 || ed_max256 !== 8'd255 || bias256 !== 18'sd65280) begin
      errors++; $display("FAIL n256_results got %0d/%0d/%0d/%0d expected 256/65280/255/65280",
                         err256, ed_sum256, ed_max256, bias256);
    end
    $display("run overflow: err=%0d ed_sum=%0d ed_max=%0d bias=%0d", err256, ed_sum256, ed_max256, bias256);
    res_ready256 = 1;
    @(negedge clk); res_ready256 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored();
    test_reset_midrun();
    test_single_sample();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
